// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display paths: segment encodings
// and anode helper functions.
package seg_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned SEL_W      = 3;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex values 0..F
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [MAX_DIGITS-1:0] an_off();
        return '1;
    endfunction

    // Active-low one-hot anode select for digit sel
    function automatic logic [MAX_DIGITS-1:0] an_sel(input logic [SEL_W-1:0] sel);
        return ~(MAX_DIGITS'(1) << sel);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0]       value,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = HEX_SEG[value];

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment scanner with frame snapshot, leading-zero
// suppression, decimal points, anti-ghost dead time and PWM brightness.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEAD_CYCLES = 64,
    parameter int unsigned BRIGHT_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic                    disp_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0]      CNT_MAX    = '1;
    localparam logic [DIV_W-1:0]      DEAD_END   = DIV_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = NUM_DIGITS'(an_off());

    logic [DIV_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic                    tick_c;
    logic                    frame_wrap_c;

    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_lz;

    logic [NUM_DIGITS-1:0]   supp_c;
    logic                    zero_run_c;

    logic [3:0]              cur_digit_c;
    logic                    cur_dp_c;
    logic                    cur_blank_c;
    logic                    cur_supp_c;
    logic [SEG_W-1:0]        dec_seg_c;

    logic                    pwm_on_c;
    logic                    window_c;
    logic [SEG_W-1:0]        seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;

    assign tick_c       = (cnt == CNT_MAX);
    assign frame_wrap_c = tick_c && (idx == IDX_LAST);

    // Slot prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
            if (tick_c) begin
                idx <= frame_wrap_c ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Frame-coherent snapshot, refreshed only as the scan returns to digit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '0;
            snap_lz     <= 1'b0;
        end else if (frame_wrap_c) begin
            snap_digits <= digits;
            snap_dp     <= dp_in;
            snap_blank  <= blank_mask;
            snap_lz     <= lz_en;
        end
    end

    // A digit is suppressed when it and every digit to its left are zero
    always_comb begin
        supp_c     = '0;
        zero_run_c = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run_c = zero_run_c && (snap_digits[4*i +: 4] == 4'h0);
            if (i > 0) begin
                supp_c[i] = snap_lz && zero_run_c;
            end
        end
    end

    always_comb begin
        cur_digit_c = '0;
        cur_dp_c    = 1'b0;
        cur_blank_c = 1'b0;
        cur_supp_c  = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit_c = snap_digits[4*i +: 4];
                cur_dp_c    = snap_dp[i];
                cur_blank_c = snap_blank[i];
                cur_supp_c  = supp_c[i];
            end
        end
    end

    seg_hex_decode u_dec (
        .value (cur_digit_c),
        .seg_c (dec_seg_c)
    );

    assign pwm_on_c = (cnt[DIV_W-1 -: BRIGHT_W] <= brightness);
    assign window_c = (cnt >= DEAD_END) && pwm_on_c && disp_en && !cur_blank_c;

    // Suppressed digits light only to show their decimal point
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        an_d  = AN_ALL_OFF;
        if (window_c && (!cur_supp_c || cur_dp_c)) begin
            an_d = NUM_DIGITS'(an_sel(SEL_W'(idx)));
            dp_d = ~cur_dp_c;
            if (!cur_supp_c) begin
                seg_d = dec_seg_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            an          <= AN_ALL_OFF;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_d;
            dp          <= dp_d;
            an          <= an_d;
            frame_start <= frame_wrap_c;
        end
    end

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan: directed scenarios plus randomized
// input traffic against a cycle-count based reference model.
module tb_seg_display_scan;

    localparam int unsigned ND   = 4;
    localparam int unsigned DW   = 4;
    localparam int unsigned DEAD = 2;
    localparam int unsigned BW   = 2;
    localparam int SLOT  = 16;
    localparam int FRAME = 64;

    logic          clk;
    logic          rst;
    logic [15:0]   digits;
    logic [3:0]    dp_in;
    logic [3:0]    blank_mask;
    logic          lz_en;
    logic          disp_en;
    logic [1:0]    brightness;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_start;

    int checks = 0;
    int errors = 0;

    seg_display_scan #(
        .NUM_DIGITS  (ND),
        .DIV_W       (DW),
        .DEAD_CYCLES (DEAD),
        .BRIGHT_W    (BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits      (digits),
        .dp_in       (dp_in),
        .blank_mask  (blank_mask),
        .lz_en       (lz_en),
        .disp_en     (disp_en),
        .brightness  (brightness),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Reference: k = clocks since reset release; position and frame follow arithmetically
    int          k;
    int          m_cnt;
    int          m_ix;
    bit          m_sup;
    bit          m_on;
    logic [15:0] s_dig;
    logic [3:0]  s_dp;
    logic [3:0]  s_blank;
    logic        s_lz;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k = 0; s_dig = '0; s_dp = '0; s_blank = '0; s_lz = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            m_cnt = k % SLOT;
            m_ix  = (k / SLOT) % int'(ND);
            m_sup = s_lz && (m_ix > 0) && ((s_dig >> (4 * m_ix)) == 16'h0);
            m_on  = (m_cnt >= int'(DEAD)) && ((m_cnt / 4) <= int'(brightness)) && disp_en
                    && !s_blank[m_ix] && (!m_sup || s_dp[m_ix]);
            e_an  = m_on ? ~(4'b0001 << m_ix) : 4'hF;
            e_seg = (m_on && !m_sup) ? hex7(s_dig[4*m_ix +: 4]) : 7'h7F;
            e_dp  = !(m_on && s_dp[m_ix]);
            e_fs  = (k % FRAME) == FRAME - 1;
            if (k % FRAME == FRAME - 1) begin
                s_dig = digits; s_dp = dp_in; s_blank = blank_mask; s_lz = lz_en;
            end
            k = k + 1;
        end
    end

    task automatic test_reset();
        rst = 1'b1; digits = '0; dp_in = '0; blank_mask = '0;
        lz_en = 1'b0; disp_en = 1'b0; brightness = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b exp 1111", an); end
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg); end
        checks++;
        if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b exp 1", dp); end
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", frame_start); end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] order [4];
        int         pos = 0;
        int         lit3 = 0;
        logic [3:0] last = 4'hF;
        order = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        digits = 16'h1234; brightness = 2'd3; disp_en = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                errors++;
                $display("FAIL scan_model i=%0d an %b/%b seg %h/%h dp %b/%b fs %b/%b",
                         i, an, e_an, seg, e_seg, dp, e_dp, frame_start, e_fs);
            end
            checks++;
            if ($countones(~an) > 1 || (an == 4'hF && seg !== 7'h7F)) begin
                errors++; $display("FAIL scan_invariant an %b seg %h", an, seg);
            end
            if (i >= FRAME && an != 4'hF && an != last) begin
                checks++;
                if (pos > 3 || an !== order[pos % 4]) begin
                    errors++; $display("FAIL scan_order got %b exp %b", an, order[pos % 4]);
                end
                pos++;
            end
            last = an;
            if (i >= FRAME && an == 4'b0111) begin
                lit3++;
                checks++;
                if (seg !== 7'h79) begin errors++; $display("FAIL scan_digit3 got %h exp 79", seg); end
            end
        end
        checks++;
        if (lit3 != 14) begin errors++; $display("FAIL scan_lit_cycles got %0d exp 14", lit3); end
        checks++;
        if (pos != 4) begin errors++; $display("FAIL scan_slots got %0d exp 4", pos); end
    endtask

    task automatic test_lz();
        int dark = 0;
        digits = 16'h0070; lz_en = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                errors++;
                $display("FAIL lz_model i=%0d an %b/%b seg %h/%h dp %b/%b", i, an, e_an, seg, e_seg, dp, e_dp);
            end
            if (i >= FRAME) begin
                if (an == 4'b0111 || an == 4'b1011) dark++;
                checks++;
                if (an == 4'b1101 && seg !== 7'h78) begin errors++; $display("FAIL lz_digit1 got %h exp 78", seg); end
                checks++;
                if (an == 4'b1110 && seg !== 7'h40) begin errors++; $display("FAIL lz_digit0 got %h exp 40", seg); end
            end
        end
        checks++;
        if (dark != 0) begin errors++; $display("FAIL lz_suppressed_lit got %0d exp 0", dark); end
        lz_en = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
                errors++; $display("FAIL lz_off_model i=%0d an %b/%b seg %h/%h", i, an, e_an, seg, e_seg);
            end
            if (i >= FRAME && (an == 4'b0111 || an == 4'b1011)) begin
                checks++;
                if (seg !== 7'h40) begin errors++; $display("FAIL lz_off_zero got %h exp 40", seg); end
            end
        end
    endtask

    task automatic test_midframe();
        int fs_cnt = 0;
        int guard;
        digits = 16'hAAAA;
        repeat (2 * FRAME) @(negedge clk);
        guard = 0;
        while (frame_start !== 1'b1 && guard < 2 * FRAME) begin @(negedge clk); guard++; end
        checks++;
        if (guard >= 2 * FRAME) begin errors++; $display("FAIL mid_wait_fs got timeout exp pulse"); end
        repeat (30) @(negedge clk);
        digits = 16'h5555;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            checks++;
            if (an != 4'hF && seg !== 7'h08) begin errors++; $display("FAIL mid_old_data got %h exp 08", seg); end
        end while (frame_start !== 1'b1 && guard < 2 * FRAME);
        checks++;
        if (guard >= 2 * FRAME) begin errors++; $display("FAIL mid_wait_fs2 got timeout exp pulse"); end
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (frame_start) fs_cnt++;
            checks++;
            if (an != 4'hF && seg !== 7'h12) begin errors++; $display("FAIL mid_new_data got %h exp 12", seg); end
            checks++;
            if (frame_start !== e_fs) begin errors++; $display("FAIL mid_fs_model got %b exp %b", frame_start, e_fs); end
        end
        checks++;
        if (fs_cnt != 4) begin errors++; $display("FAIL mid_fs_count got %0d exp 4", fs_cnt); end
    endtask

    task automatic test_brightness();
        int on_cnt [4];
        logic [1:0] levels [2];
        int exp_on [2];
        levels = '{2'd0, 2'd1};
        exp_on = '{2, 6};
        for (int l = 0; l < 2; l++) begin
            brightness = levels[l];
            on_cnt = '{0, 0, 0, 0};
            @(negedge clk);
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                for (int d = 0; d < 4; d++) if (an[d] == 1'b0) on_cnt[d]++;
                checks++;
                if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
                    errors++; $display("FAIL bright_model an %b/%b seg %h/%h", an, e_an, seg, e_seg);
                end
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (on_cnt[d] != exp_on[l]) begin
                    errors++; $display("FAIL bright_duty lvl=%0d dig=%0d got %0d exp %0d", l, d, on_cnt[d], exp_on[l]);
                end
            end
        end
    endtask

    task automatic test_blank_dp();
        int dp_lit = 0;
        brightness = 2'd3; digits = 16'h1234; blank_mask = 4'b0100; dp_in = 4'b0010;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
                errors++; $display("FAIL blank_model an %b/%b seg %h/%h dp %b/%b", an, e_an, seg, e_seg, dp, e_dp);
            end
            if (i >= FRAME) begin
                checks++;
                if (an == 4'b1011) begin errors++; $display("FAIL blank_digit2 got %b exp never", an); end
                if (dp == 1'b0) begin
                    dp_lit++;
                    checks++;
                    if (an !== 4'b1101) begin errors++; $display("FAIL dp_anode got %b exp 1101", an); end
                end
            end
        end
        checks++;
        if (dp_lit != 14) begin errors++; $display("FAIL dp_lit_cycles got %0d exp 14", dp_lit); end
        blank_mask = '0; dp_in = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                errors++;
                $display("FAIL rand_model i=%0d an %b/%b seg %h/%h dp %b/%b fs %b/%b",
                         i, an, e_an, seg, e_seg, dp, e_dp, frame_start, e_fs);
            end
            checks++;
            if ($countones(~an) > 1 || (an == 4'hF && seg !== 7'h7F)) begin
                errors++; $display("FAIL rand_invariant an %b seg %h", an, seg);
            end
            if ($urandom_range(0, 15) == 0) begin
                for (int d = 0; d < 4; d++)
                    digits[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                dp_in      = 4'($urandom);
                blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                lz_en      = 1'($urandom);
            end
            if ($urandom_range(0, 31) == 0) begin
                disp_en    = ($urandom_range(0, 3) != 0);
                brightness = 2'($urandom);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int first_fs = -1;
        blank_mask = '0; dp_in = '0; lz_en = 1'b0; disp_en = 1'b1; brightness = 2'd3; digits = 16'h9876;
        while (an == 4'hF && guard < 3 * FRAME) begin @(negedge clk); guard++; end
        repeat (3) @(negedge clk);
        checks++;
        if (an == 4'hF) begin errors++; $display("FAIL rmid_wait_lit got %b exp lit", an); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
            errors++; $display("FAIL rmid_async an %b seg %h dp %b exp 1111 7f 1", an, seg, dp);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) begin
            @(negedge clk);
            if (frame_start && first_fs < 0) first_fs = i;
            checks++;
            if ({an, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
                errors++; $display("FAIL rmid_model i=%0d an %b/%b seg %h/%h", i, an, e_an, seg, e_seg);
            end
            if (i < 2) begin
                checks++;
                if (an !== 4'hF) begin errors++; $display("FAIL rmid_dead i=%0d got %b exp 1111", i, an); end
            end
            if (i == 2) begin
                checks++;
                if (an !== 4'b1110 || seg !== 7'h40) begin
                    errors++; $display("FAIL rmid_restart an %b seg %h exp 1110 40", an, seg);
                end
            end
        end
        checks++;
        if (first_fs != FRAME - 1) begin errors++; $display("FAIL rmid_first_fs got %0d exp %0d", first_fs, FRAME - 1); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_midframe();
        test_brightness();
        test_blank_dp();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
